dht11_sensor_model: RTL and testbench
=====================================

// Module: dht11_sensor_model
// PURPOSE
//  Synthesizable DHT11 responder: emulates the sensor end of the single-wire bus for FPGA loopback tests of the DHT11 host controller.
//  Detects the host start pulse, sends the response preamble, then 40 data bits: hum_int, hum_dec, temp_int, temp_dec, checksum, MSB first.
//  Open-drain only: drives 0 or releases to 'z'. An external pull-up (or the bench's pullup) makes the idle level 1.
// PARAMETERS
//  CLK_FREQ_HZ    100_000_000  system clock frequency; CLK_PER_US = CLK_FREQ_HZ/1_000_000
//  MIN_START_US   18000        minimum host low time accepted as a start request
//  T_WAIT_US      30           delay from host release to the sensor pulling the line low
//  T_RESP_US      80           response low time; also response high time
//  T_BIT_LOW_US   50           low lead-in before every bit and the final end-of-frame low
//  T_ZERO_US      26           high time encoding a 0
//  T_ONE_US       70           high time encoding a 1
// PORTS
//  clk        in     1  system clock
//  rst        in     1  synchronous, active-high reset
//  data       inout  1  DHT11 bus; driven 1'b0 or 1'bz, never 1'b1
//  hum_int    in     8  humidity integral byte
//  hum_dec    in     8  humidity decimal byte
//  temp_int   in     8  temperature integral byte
//  temp_dec   in     8  temperature decimal byte
//  busy       out    1  high from accepted start (host release) until the line is released after END_LOW
//  done       out    1  one-cycle pulse on the cycle the line is released after END_LOW
// BEHAVIOUR
//  - Reset: data='z', busy=0, done=0, state=IDLE, counters cleared. Reset mid-frame releases the line on the next clk edge.
//  - Bus input path: data passes through a 2-flop synchronizer (data_s). All decisions use data_s.
//  - Timing: a us tick comes every CLK_PER_US clocks. The prescaler and the us counter clear on every state change, so an N-us phase is exactly N*CLK_PER_US cycles (+/-0 clk).
//  - us counter is 15 bits and saturates; it does not wrap.
//  - States and transitions:
//    IDLE      : release; data_s==0 -> START_LOW
//    START_LOW : release; count us while data_s==0;
//                data_s==1 with count<MIN_START_US -> IDLE (glitch/short pulse ignored, no response);
//                data_s==1 with count>=MIN_START_US -> RESP_DLY
//    RESP_DLY  : release; latch the 4 input bytes into shift_reg[39:0] with checksum = sum of the 4 bytes mod 256, bits[39:32]=hum_int;
//                busy=1; after T_WAIT_US -> RESP_LOW
//    RESP_LOW  : drive 0 for T_RESP_US -> RESP_HIGH
//    RESP_HIGH : release for T_RESP_US -> BIT_LOW; bit_cnt=0
//    BIT_LOW   : drive 0 for T_BIT_LOW_US -> BIT_HIGH
//    BIT_HIGH  : release for T_ONE_US if shift_reg[39] else T_ZERO_US; then shift left, bit_cnt++;
//                bit_cnt==40 -> END_LOW else BIT_LOW
//    END_LOW   : drive 0 for T_BIT_LOW_US -> IDLE; release, busy=0, done=1 for one cycle
//  - While busy, data_s is ignored (host activity cannot abort a frame); only rst aborts.
//  - Input bytes changing after RESP_DLY entry do not affect the frame in flight.
//  - On IDLE return, the line is already released; a new start needs a fresh falling edge seen in IDLE.
// STRUCTURE
//  - dht11_pkg: state enum dht11_state_e (IDLE..END_LOW), NUM_BITS=40, timing default localparams shared with the host controller.
//  - Sub-module dht11_us_tick: prescaler with synchronous clr input and a 1-cycle tick output, parameter CLK_PER_US.
//  - Top level: synchronizer, FSM, us counter, 40-bit shift register, bit counter, tri-state assign.
// TESTING (100 MHz clk, pullup on data, host modelled in the bench)
//  1. hum=53/0, temp=24/0; host low 18 ms then release -> after 30 us: low 80 us, high 80 us; bytes 0x35,0x00,0x18,0x00,0x4D decoded correctly; done pulse once; data='z' afterwards.
//  2. Host low 5 ms, then release -> no drive on data, busy stays 0, FSM back in IDLE.
//  3. rst asserted during bit 10 -> data='z' the next cycle, busy=0; the next 18 ms start gives a full correct frame.
//  4. Checksum wrap: hum=200/100, temp=0/0 -> checksum byte 0x2C.
//  5. Change the inputs to 99/99/99/99 during bit 5 -> the frame still carries the bytes latched at RESP_DLY.
//  6. Two back-to-back starts, 1 ms apart after done -> two correct frames; each phase width is exact to N*100 cycles.

Source files
------------

// File: rtl/dht11_pkg.sv
// dht11_pkg: shared DHT11 state encoding, frame size, default bus timing and checksum helper
package dht11_pkg;
  typedef enum logic [2:0] {
    IDLE,
    START_LOW,
    RESP_DLY,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } dht11_state_e;
  localparam int NUM_BITS         = 40;
  localparam int DEF_CLK_FREQ_HZ  = 100_000_000;
  localparam int DEF_MIN_START_US = 18000;
  localparam int DEF_T_WAIT_US    = 30;
  localparam int DEF_T_RESP_US    = 80;
  localparam int DEF_T_BIT_LOW_US = 50;
  localparam int DEF_T_ZERO_US    = 26;
  localparam int DEF_T_ONE_US     = 70;
  function automatic logic [7:0] checksum(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction
  function automatic logic drives_low(input dht11_state_e s);
    return s inside {RESP_LOW, BIT_LOW, END_LOW};
  endfunction
endpackage

// File: rtl/dht11_us_tick.sv
// dht11_us_tick: microsecond prescaler, restartable so every phase begins on a whole-us boundary
module dht11_us_tick #(
  parameter int CLK_PER_US = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = $clog2(CLK_PER_US) > 0 ? $clog2(CLK_PER_US) : 1;
  logic [W-1:0] cnt_q;
  assign tick_o = cnt_q == W'(CLK_PER_US - 1);
  // count clocks, restarting on wrap or on a state change
  always_ff @(posedge clk)
    cnt_q <= (rst || clr_i || tick_o) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/dht11_sensor_model.sv
// dht11_sensor_model: open-drain DHT11 responder answering a host start with preamble and 40-bit frame
module dht11_sensor_model
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = DEF_CLK_FREQ_HZ,
  parameter int MIN_START_US = DEF_MIN_START_US,
  parameter int T_WAIT_US    = DEF_T_WAIT_US,
  parameter int T_RESP_US    = DEF_T_RESP_US,
  parameter int T_BIT_LOW_US = DEF_T_BIT_LOW_US,
  parameter int T_ZERO_US    = DEF_T_ZERO_US,
  parameter int T_ONE_US     = DEF_T_ONE_US
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        data,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       busy,
  output logic       done
);
  localparam int CLK_PER_US = CLK_FREQ_HZ / 1_000_000;
  dht11_state_e state_q, state_d;
  logic [1:0]  sync_q;
  logic [14:0] us_q, len;
  logic [39:0] sr_q;
  logic [5:0]  bit_q;
  logic        drive_q, busy_q, done_q;
  logic        data_s, tick, clr, fin;
  assign data_s = sync_q[1];
  assign clr    = state_d != state_q;
  assign data   = drive_q ? 1'b0 : 1'bz;
  assign busy   = busy_q;
  assign done   = done_q;
  dht11_us_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .tick_o(tick)
  );
  // phase length of the current state and next-state selection
  always_comb begin
    len = 15'(state_q == RESP_DLY ? T_WAIT_US :
              (state_q == RESP_LOW || state_q == RESP_HIGH) ? T_RESP_US :
              state_q == BIT_HIGH ? (sr_q[39] ? T_ONE_US : T_ZERO_US) : T_BIT_LOW_US);
    fin = tick && us_q == len - 15'd1;
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!data_s) state_d = START_LOW;
      START_LOW: if (data_s) state_d = us_q >= 15'(MIN_START_US) ? RESP_DLY : IDLE;
      RESP_DLY:  if (fin) state_d = RESP_LOW;
      RESP_LOW:  if (fin) state_d = RESP_HIGH;
      RESP_HIGH: if (fin) state_d = BIT_LOW;
      BIT_LOW:   if (fin) state_d = BIT_HIGH;
      BIT_HIGH:  if (fin) state_d = bit_q == 6'(NUM_BITS - 1) ? END_LOW : BIT_LOW;
      END_LOW:   if (fin) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // state, us counter, frame shifter and registered bus/status outputs
  always_ff @(posedge clk)
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      us_q    <= '0;
      sr_q    <= '0;
      bit_q   <= '0;
      drive_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], data};
      state_q <= state_d;
      us_q    <= clr ? '0 : (tick && us_q != '1) ? us_q + 1'b1 : us_q;
      if (state_q == START_LOW && state_d == RESP_DLY)
        sr_q <= {hum_int, hum_dec, temp_int, temp_dec, checksum(hum_int, hum_dec, temp_int, temp_dec)};
      else if (state_q == BIT_HIGH && fin)
        sr_q <= {sr_q[38:0], 1'b0};
      bit_q   <= state_q == RESP_HIGH ? '0 : (state_q == BIT_HIGH && fin) ? bit_q + 1'b1 : bit_q;
      drive_q <= drives_low(state_d);
      busy_q  <= !(state_d inside {IDLE, START_LOW});
      done_q  <= state_q == END_LOW && state_d == IDLE;
    end
endmodule

// File: tb/tb_dht11_sensor_model.sv
// tb_dht11_sensor_model: randomized host starts, frame scoreboard and bus-decoding monitor
module tb_dht11_sensor_model;
  localparam int CPU     = 4;
  localparam int MIN_US  = 200;
  localparam int WAIT_US = 3;
  localparam int RESP_US = 8;
  localparam int BL_US   = 5;
  localparam int ZERO_US = 3;
  localparam int ONE_US  = 7;
  logic clk = 1'b0, rst = 1'b1, host_low = 1'b0;
  logic [7:0] hi = 8'd0, hd = 8'd0, ti = 8'd0, td = 8'd0;
  logic busy, done;
  wire data;
  pullup (data);
  assign data = host_low ? 1'b0 : 1'bz;
  dht11_sensor_model #(
    .CLK_FREQ_HZ (CPU * 1_000_000),
    .MIN_START_US(MIN_US),
    .T_WAIT_US   (WAIT_US),
    .T_RESP_US   (RESP_US),
    .T_BIT_LOW_US(BL_US),
    .T_ZERO_US   (ZERO_US),
    .T_ONE_US    (ONE_US)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data    (data),
    .hum_int (hi),
    .hum_dec (hd),
    .temp_int(ti),
    .temp_dec(td),
    .busy    (busy),
    .done    (done)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, rel_cyc = 0, ph = 0, done_cnt = 0, frames = 0;
  logic [39:0] exp_q[$];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic logic [39:0] frame_of(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
    int s;
    s = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
    return {a, b, c, d, 8'(s)};
  endfunction

  task automatic set_in(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    hi = a; hd = b; ti = c; td = d;
  endtask

  task automatic host_start(input int us);
    @(posedge clk); #1 host_low = 1'b1;
    repeat (us * CPU) @(posedge clk);
    #1 host_low = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    set_in(a, b, c, d);
    exp_q.push_back(frame_of(a, b, c, d));
    frames++;
    host_start(MIN_US + 20);
  endtask

  task automatic rnd_frame();
    frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 6000);
    chk("done_seen", done, 1);
  endtask

  task automatic wait_ph(input int p);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (ph < p && n < 6000);
    chk("reach_phase", ph >= p, 1);
  endtask

  // monitor: decode sensor-driven run lengths and compare with the front of the scoreboard
  initial begin
    logic lv, pv, eb, have;
    int run, i;
    logic [39:0] cur, got;
    pv = 1'b0; run = 0; have = 1'b0; cur = '0; got = '0;
    forever begin
      @(negedge clk);
      lv = (data === 1'b0) && !host_low;
      if (done) done_cnt++;
      if (rst) ph = 0;
      else if (ph == 0) begin
        if (lv) begin
          chk("resp_delay", (cyc - rel_cyc >= WAIT_US * CPU + 1) && (cyc - rel_cyc <= WAIT_US * CPU + 5), 1);
          have = exp_q.size() > 0;
          cur = have ? exp_q[0] : '0;
          chk("frame_expected", have, 1);
          ph = 1; run = 1; got = '0;
        end
      end else if (lv == pv) run++;
      else begin
        if (ph == 1) chk("resp_low", run, RESP_US * CPU);
        else if (ph == 2) chk("resp_high", run, RESP_US * CPU);
        else if (ph == 83) begin
          chk("end_low", run, BL_US * CPU);
          chk("done_at_release", done, 1);
          chk("busy_clear", busy, 0);
          if (have) begin
            void'(exp_q.pop_front());
            chk("frame_bits", got, cur);
          end
        end else if (ph % 2 == 1) chk("bit_low", run, BL_US * CPU);
        else begin
          i = (ph - 4) / 2;
          eb = cur[39 - i];
          got = {got[38:0], run > (ZERO_US + ONE_US) * CPU / 2};
          chk("bit_high", run, (eb ? ONE_US : ZERO_US) * CPU);
        end
        ph = ph == 83 ? 0 : ph + 1;
        run = 1;
      end
      pv = lv;
    end
  end

  initial begin
    logic bad;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_line", data === 1'b1, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    frame(8'd53, 8'd0, 8'd24, 8'd0);
    wait_done();
    @(negedge clk);
    chk("released_after", data === 1'b1, 1);
    chk("done_one_cycle", done, 0);
    set_in(8'd1, 8'd2, 8'd3, 8'd4);
    host_start(MIN_US / 4);
    bad = 1'b0;
    repeat ((WAIT_US + 2 * RESP_US) * CPU * 2) begin
      @(negedge clk);
      if (busy || (data === 1'b0 && !host_low)) bad = 1'b1;
    end
    chk("short_pulse_ignored", bad, 0);
    chk("fsm_idle", dut.state_q == dht11_pkg::IDLE, 1);
    rnd_frame();
    wait_ph(23);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_line", data === 1'b1, 1);
    chk("abort_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    void'(exp_q.pop_front());
    frames--;
    rnd_frame();
    wait_done();
    frame(8'd200, 8'd100, 8'd0, 8'd0);
    chk("wrap_checksum_ref", exp_q[exp_q.size() - 1][7:0], 8'h2C);
    wait_done();
    rnd_frame();
    wait_ph(13);
    set_in(8'd99, 8'd99, 8'd99, 8'd99);
    wait_done();
    for (int k = 0; k < 2; k++) begin
      rnd_frame();
      wait_done();
      repeat (100 * CPU) @(posedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      rnd_frame();
      wait_done();
    end
    repeat (10) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("done_count", done_cnt, frames);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
